// File: rtl/cpu_types_pkg.sv
// Shared CPU types. This slice holds the instruction-cache address overlay,
// frame layout and controller states, sized for the default 16-frame cache.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  // Field view of a 32-bit fetch address.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  // One direct-mapped frame.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  // Fill controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage : cpu_types_pkg

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache. Hits are served combinationally
// in the request cycle; a miss performs a single-word fill over iREN/iwait and
// the filled word hits on the cycle after the grant.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  // Frame storage, split so only the valid bits carry a reset.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  icache_state_t    state_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;

  // Address split of the incoming fetch; the byte offset plays no part.
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             unused_bytoff;
  logic             hit;
  logic             fill_done;

  assign req_tag       = imemaddr[31:IDX_W+2];
  assign req_idx       = imemaddr[IDX_W+1:2];
  assign unused_bytoff = ^imemaddr[1:0];

  assign hit       = (state_q == IDLE) && imemREN && valid_q[req_idx]
                     && (tag_q[req_idx] == req_tag);
  assign fill_done = (state_q == FETCH) && !iwait;

  // Fill controller: latch the missing word address, then wait for the grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, whatever order the blocks are evaluated in.
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !hit) begin
            state_q    <= FETCH;
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
          end
        end
        FETCH: begin
          if (!iwait) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid bits: cleared only by reset, set by a completed fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[miss_idx_q] <= 1'b1;
    end
  end

  // Tag and data payload, written on fill completion.
  // NOTE: the payload array is deliberately left out of reset; a cleared valid
  // bit already hides stale contents, and reset-free storage maps to plain flops
  // or RAM without a wide reset fan-out.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= iload;
    end
  end

  // Output decode: hit path in IDLE, memory request in FETCH.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves one unassigned, which would otherwise infer a latch.
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (state_q == FETCH) begin
      iREN  = 1'b1;
      iaddr = {miss_tag_q, miss_idx_q, 2'b00};
    end else if (hit) begin
      ihit     = 1'b1;
      imemload = data_q[req_idx];
    end
  end

endmodule : icache_direct
